board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles a row select is held before sampling (legal range 4..255).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3, meaning consecutive identical frames required to commit a board image (legal range 1..15).
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port col_in, input, 4 bits: asynchronous, active-low sensor columns from the JA header; 0 means piece present.
REQ-006 SHALL have port row_sel, output, 3 bits: row currently driven to the external demux.
REQ-007 SHALL have port board_state, output, 32 bits: last committed occupancy image of the 32 dark squares.
REQ-008 SHALL have port board_valid, output, 1 bit: at least one image has been committed since reset.
REQ-009 SHALL have port changed, output, 1 bit: sticky flag, board_state updated since last ack.
REQ-010 SHALL have port ack, input, 1 bit: single-cycle consumer acknowledge that clears changed.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of every full 8-row frame.

Function
REQ-012 SHALL pass col_in through a two-flop synchroniser before any use.
REQ-013 SHALL run FSM states SETTLE, SAMPLE, COMMIT; reset state SETTLE with row_sel=0 and settle counter=0.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-015 SAMPLE SHALL last one cycle, write scan_buf[row_sel*4+c] = ~col_sync[c] for c=0..3, then increment row_sel and go to SETTLE if row_sel<7, else go to COMMIT.
REQ-016 COMMIT SHALL last one cycle, pulse frame_done, set row_sel=0, and return to SETTLE; one frame is therefore 8*(SETTLE_CYCLES+1)+1 cycles.
REQ-017 In COMMIT, if scan_buf != candidate, SHALL load candidate=scan_buf and set stable_cnt=1; otherwise stable_cnt SHALL saturate-increment at DEBOUNCE_SCANS.
REQ-018 In COMMIT, when the resulting stable_cnt == DEBOUNCE_SCANS and candidate (post-update) differs from board_state or board_valid=0, SHALL load board_state=candidate, set board_valid=1, and set changed=1 on the next edge.
REQ-019 An unchanged committed image SHALL NOT set changed again.
REQ-020 ack SHALL clear changed on the next edge; if ack and a commit update coincide, changed SHALL remain 1.
REQ-021 ack while changed=0 SHALL have no effect.
REQ-022 row_sel SHALL wrap 7->0 only via COMMIT, never skipping or repeating a row within a frame.
REQ-023 board_state SHALL be stable between commits; no partial-frame values SHALL be visible.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately force row_sel=0, board_state=0, board_valid=0, changed=0, frame_done=0, stable_cnt=0, candidate=0, scan_buf=0, synchroniser flops=1 (idle, no piece).
REQ-025 After reset deassertion, scanning SHALL restart from row 0 in SETTLE; no image from before reset SHALL be committed.

Structure
REQ-026 FSM state encoding, bit-mapping constant (4 columns x 8 rows) and parameter defaults SHALL live in a shared package sensor_pkg used also by the sensor manager.
REQ-027 The two-flop synchroniser SHALL be a separate sub-module sync_2ff, instantiated once with width 4.

Verification (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, frame=41 cycles)
REQ-028 Reset asserted mid-SETTLE of row 5 -> same cycle row_sel=0, board_state=0x00000000, board_valid=0, changed=0.
REQ-029 col_in=4'b0000 constant from reset release -> third frame_done coincides with commit; next cycle board_state=0xFFFFFFFF, board_valid=1, changed=1.
REQ-030 col_in=4'b1110 only while row_sel=3, else 4'b1111 -> after three frames board_state=0x00001000.
REQ-031 Stable 0xFFFFFFFF committed, then col_in[1]=1 during row 1 for exactly one frame -> board_state stays 0xFFFFFFFF, changed not re-asserted.
REQ-032 ack asserted in the same cycle a new image commits -> changed=1 afterwards; ack one cycle later -> changed=0.
REQ-033 Bench SHALL check frame_done period of exactly 41 cycles over 10 frames and row_sel sequence 0..7 per frame.

Source files
------------

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared board-sensor constants, scan FSM encoding and bit mapping
// Purpose: constants and types shared by the board scanner and the sensor manager.
// Ports: none (package).
package sensor_pkg;

    localparam int NUM_COLS               = 4;
    localparam int NUM_ROWS               = 8;
    localparam int BOARD_BITS             = NUM_COLS * NUM_ROWS;
    localparam int SETTLE_CYCLES_DEFAULT  = 4;
    localparam int DEBOUNCE_SCANS_DEFAULT = 3;

    typedef enum logic [1:0] {
        SCAN_SETTLE = 2'd0,
        SCAN_SAMPLE = 2'd1,
        SCAN_COMMIT = 2'd2
    } scan_state_t;

    // Square (row, col) maps to board bit row*NUM_COLS + col.
    function automatic logic [4:0] row_base(input logic [2:0] row);
        return {row, 2'b00};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous inputs
// Purpose: brings an asynchronous bus into the clock domain.
// Ports: clock, reset (async, active-high), d (async input), q (synchronised output).
module sync_2ff #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/board_scanner.sv
// rtl/board_scanner.sv - row-multiplexed board occupancy scanner with frame debounce
// Purpose: drives row_sel through 8 rows, samples 4 active-low columns per row,
//          and commits a 32-bit occupancy image after DEBOUNCE_SCANS identical frames.
// Ports: clock, reset (async, active-high), col_in (async active-low columns),
//        row_sel (current row), board_state (committed image), board_valid,
//        changed (sticky, cleared by ack), ack, frame_done (end-of-frame pulse).
module board_scanner
    import sensor_pkg::*;
#(
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_COLS-1:0]   col_in,
    output logic [2:0]            row_sel,
    output logic [BOARD_BITS-1:0] board_state,
    output logic                  board_valid,
    output logic                  changed,
    input  logic                  ack,
    output logic                  frame_done
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB_TARGET  = 4'(DEBOUNCE_SCANS);

    scan_state_t           state, state_next;
    logic [7:0]            settle_cnt;
    logic                  settle_done;
    logic [NUM_COLS-1:0]   col_sync;
    logic [BOARD_BITS-1:0] scan_buf;
    logic [BOARD_BITS-1:0] candidate, cand_next;
    logic [3:0]            stable_cnt, cnt_next;
    logic                  commit_update;

    sync_2ff #(.WIDTH(NUM_COLS), .RESET_VALUE('1)) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_in),
        .q     (col_sync)
    );

    assign settle_done = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= SCAN_SETTLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            SCAN_SETTLE: if (settle_done) state_next = SCAN_SAMPLE;
            SCAN_SAMPLE: state_next = (row_sel == 3'd7) ? SCAN_COMMIT : SCAN_SETTLE;
            SCAN_COMMIT: begin
                frame_done = 1'b1;
                state_next = SCAN_SETTLE;
            end
            default:     state_next = SCAN_SETTLE;
        endcase
    end

    // Debounce: a new frame image restarts the count; a repeat saturates it.
    // The commit decision uses the post-update candidate/count.
    always_comb begin
        cand_next = candidate;
        cnt_next  = stable_cnt;
        if (scan_buf != candidate) begin
            cand_next = scan_buf;
            cnt_next  = 4'd1;
        end else if (stable_cnt != DEB_TARGET) begin
            cnt_next  = stable_cnt + 4'd1;
        end
        commit_update = (state == SCAN_COMMIT) && (cnt_next == DEB_TARGET) &&
                        ((cand_next != board_state) || !board_valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_cnt  <= '0;
            row_sel     <= '0;
            scan_buf    <= '0;
            candidate   <= '0;
            stable_cnt  <= '0;
            board_state <= '0;
            board_valid <= 1'b0;
            changed     <= 1'b0;
        end else begin
            settle_cnt <= (state == SCAN_SETTLE && !settle_done) ? settle_cnt + 8'd1 : 8'd0;

            if (state == SCAN_SAMPLE) begin
                scan_buf[row_base(row_sel) +: NUM_COLS] <= ~col_sync;
                if (row_sel != 3'd7) row_sel <= row_sel + 3'd1;
            end

            if (state == SCAN_COMMIT) begin
                row_sel    <= 3'd0;
                candidate  <= cand_next;
                stable_cnt <= cnt_next;
            end

            if (commit_update) begin
                board_state <= cand_next;
                board_valid <= 1'b1;
            end

            // A commit in the same cycle as ack wins so the new image is not missed.
            if (commit_update) changed <= 1'b1;
            else if (ack)      changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
// tb/tb_board_scanner.sv - scoreboard testbench for board_scanner
module tb_board_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int FRAME  = 8 * (SETTLE + 1) + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  col_in;
    logic [2:0]  row_sel;
    logic [31:0] board_state;
    logic        board_valid;
    logic        changed;
    logic        ack;
    logic        frame_done;

    board_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
        .clock       (clock),
        .reset       (reset),
        .col_in      (col_in),
        .row_sel     (row_sel),
        .board_state (board_state),
        .board_valid (board_valid),
        .changed     (changed),
        .ack         (ack),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] board;
        logic        valid;
        logic        chg;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] cur_image;
    logic [31:0] m_cand, m_board;
    int          m_cnt;
    logic        m_valid, m_chg;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_fd;
    bit          have_last;

    always @(posedge clock) cyc <= cyc + 1;

    // Sensor board: a present piece pulls its column low while its row is selected.
    always_comb col_in = ~cur_image[{row_sel, 2'b00} +: 4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cand = '0; m_board = '0; m_cnt = 0; m_valid = 1'b0; m_chg = 1'b0;
        have_last = 1'b0;
        sb_q.delete();
    endtask

    // Present one frame of img starting at row 0; optionally ack during COMMIT.
    task automatic do_frame(input logic [31:0] img, input logic ack_c);
        exp_t       e;
        int         bad;
        logic [2:0] prev;
        bit         got;
        cur_image = img;
        if (img != m_cand) begin
            m_cand = img;
            m_cnt  = 1;
        end else if (m_cnt < DEB) begin
            m_cnt++;
        end
        if (m_cnt == DEB && (m_cand != m_board || !m_valid)) begin
            m_board = m_cand; m_valid = 1'b1; m_chg = 1'b1;
        end else if (ack_c) begin
            m_chg = 1'b0;
        end
        e.board = m_board; e.valid = m_valid; e.chg = m_chg;
        sb_q.push_back(e);

        check("row_start", 32'(row_sel), 32'd0);
        prev = 3'd0; bad = 0; got = 1'b0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            @(negedge clock);
            if (row_sel != prev) begin
                if (row_sel != prev + 3'd1) bad++;
                prev = row_sel;
            end
            if (frame_done) got = 1'b1;
        end
        if (!got) begin
            check("frame_done_timeout", 32'd0, 32'd1);
            return;
        end
        check("row_last", 32'(row_sel), 32'd7);
        check("row_steps", 32'(bad), 32'd0);
        if (have_last) check("fd_period", 32'(cyc - last_fd), 32'(FRAME));
        last_fd   = cyc;
        have_last = 1'b1;

        ack = ack_c;
        @(negedge clock);
        ack = 1'b0;
        check("fd_pulse_width", 32'(frame_done), 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("board_state", board_state, e.board);
            check("board_valid", 32'(board_valid), 32'(e.valid));
            check("changed", 32'(changed), 32'(e.chg));
        end
        check("row_wrap", 32'(row_sel), 32'd0);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        m_chg = 1'b0;
        check("changed_after_ack", 32'(changed), 32'(m_chg));
    endtask

    initial begin
        bit got;
        reset = 1'b1;
        ack   = 1'b0;
        cur_image = 32'hFFFF_FFFF;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_row_sel", 32'(row_sel), 32'd0);
        check("rst_board_state", board_state, 32'd0);
        check("rst_board_valid", 32'(board_valid), 32'd0);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        // All squares occupied: commits on the third frame.
        for (int f = 0; f < 4; f++) do_frame(32'hFFFF_FFFF, 1'b0);
        ack_pulse();

        // Single-frame glitch on row 1 column 1 must not re-commit.
        do_frame(32'hFFFF_FFDF, 1'b0);
        for (int f = 0; f < 3; f++) do_frame(32'hFFFF_FFFF, 1'b0);

        // Single piece at row 3 column 0; ack coincides with the commit.
        do_frame(32'h0000_1000, 1'b0);
        do_frame(32'h0000_1000, 1'b0);
        do_frame(32'h0000_1000, 1'b1);
        check("req_image", board_state, 32'h0000_1000);
        ack_pulse();
        do_frame(32'h0000_1000, 1'b0);
        ack_pulse();

        // Flapping images never reach the debounce count.
        do_frame(32'h0F0F_0F0F, 1'b0);
        do_frame(32'hF0F0_F0F0, 1'b0);
        do_frame(32'h0F0F_0F0F, 1'b0);
        do_frame(32'h0F0F_0F0F, 1'b0);

        // Reset mid-SETTLE of row 5.
        got = 1'b0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            @(negedge clock);
            if (row_sel == 3'd5) got = 1'b1;
        end
        check("wait_row5", 32'(got), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_row_sel", 32'(row_sel), 32'd0);
        check("mid_rst_board_state", board_state, 32'd0);
        check("mid_rst_board_valid", 32'(board_valid), 32'd0);
        check("mid_rst_changed", 32'(changed), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        cur_image = 32'h1234_5678;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int f = 0; f < 3; f++) do_frame(32'h1234_5678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
